pipe_hazard_sequencer: RTL and testbench

//  Multi-cycle pipeline control sequencer. Sits beside the hazard detector and owns every stall/flush

---
 rtl/pipe_hazard_sequencer.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sequencer.sv
// Pipeline stall/flush sequencer for the F/D/E/W pipeline.
// Arbitrates taken-branch flushes, load-use bubbles and multi-cycle data
// memory waits, and keeps a saturating count of stalled cycles.
module pipe_hazard_sequencer #(
  parameter int unsigned BR_FLUSH_CYCLES = 2,
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter int unsigned PERF_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_en,
  input  logic              load_use_hzd,
  input  logic              mem_req_E,
  input  logic              mem_ack,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              flush_F,
  output logic              flush_D,
  output logic              flush_E,
  output logic              alu_en,
  output logic              busy,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, BRF, LUS, MEMW} state_e;

  localparam logic [7:0] BR_CNT0  = 8'(BR_FLUSH_CYCLES - 2);
  localparam logic [7:0] LU_CNT0  = 8'(LU_STALL_CYCLES - 2);
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic st_f_c, st_d_c, st_e_c;
  logic fl_f_c, fl_d_c, fl_e_c;
  logic alu_c, err_c;

  // State, duration counters and perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      tmo_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state plus stall/flush decode: request-driven in RUN, state-driven elsewhere
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    st_f_c  = 1'b0;
    st_d_c  = 1'b0;
    st_e_c  = 1'b0;
    fl_f_c  = 1'b0;
    fl_d_c  = 1'b0;
    fl_e_c  = 1'b0;
    alu_c   = 1'b1;
    err_c   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_en) begin
          fl_f_c = 1'b1;
          fl_d_c = 1'b1;
          alu_c  = 1'b0;
          if (BR_FLUSH_CYCLES > 1) begin
            state_d = BRF;
            cnt_d   = BR_CNT0;
          end
        end else if (mem_req_E && !mem_ack) begin
          st_f_c  = 1'b1;
          st_d_c  = 1'b1;
          st_e_c  = 1'b1;
          alu_c   = 1'b0;
          state_d = MEMW;
          tmo_d   = '0;
        end else if (load_use_hzd) begin
          st_f_c = 1'b1;
          st_d_c = 1'b1;
          fl_e_c = 1'b1;
          if (LU_STALL_CYCLES > 1) begin
            state_d = LUS;
            cnt_d   = LU_CNT0;
          end
        end
      end
      BRF: begin
        fl_f_c = 1'b1;
        fl_d_c = 1'b1;
        alu_c  = 1'b0;
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 8'd1;
      end
      LUS: begin
        st_f_c = 1'b1;
        st_d_c = 1'b1;
        fl_e_c = 1'b1;
        if (branch_en || cnt_q == '0) state_d = RUN;
        else                          cnt_d   = cnt_q - 8'd1;
      end
      MEMW: begin
        st_f_c = 1'b1;
        st_d_c = 1'b1;
        st_e_c = 1'b1;
        alu_c  = 1'b0;
        tmo_d  = tmo_q + 8'd1;
        if (mem_ack) begin
          state_d = RUN;
        end else if (tmo_q == TMO_LAST) begin
          err_c   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating count of cycles with any stall line raised
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((st_f_c || st_d_c || st_e_c) && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // RUN decode reacts to live inputs, so outputs are masked while reset is
  // held to keep a held request from showing a stall during reset.
  assign stall_F   = st_f_c & rst_n;
  assign stall_D   = st_d_c & rst_n;
  assign stall_E   = st_e_c & rst_n;
  assign flush_F   = fl_f_c & rst_n;
  assign flush_D   = fl_d_c & rst_n;
  assign flush_E   = fl_e_c & rst_n;
  assign alu_en    = alu_c | ~rst_n;
  assign mem_err   = err_c & rst_n;
  assign busy      = (state_q != RUN);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// Bench for pipe_hazard_sequencer: two parameterisations driven by the same
// stimulus, checked every cycle against a plan-based reference model, plus
// directed literal checks on the default-parameter instance.
module tb_pipe_hazard_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch_en = 1'b0, load_use_hzd = 1'b0, mem_req_E = 1'b0, mem_ack = 1'b0;

  // {stall_F, stall_D, stall_E, flush_F, flush_D, flush_E, alu_en, busy, mem_err}
  logic [8:0]  v0, v1;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_sequencer #(
    .BR_FLUSH_CYCLES(2), .LU_STALL_CYCLES(1), .MEM_TIMEOUT(15), .PERF_W(16)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .branch_en(branch_en), .load_use_hzd(load_use_hzd),
    .mem_req_E(mem_req_E), .mem_ack(mem_ack),
    .stall_F(v0[8]), .stall_D(v0[7]), .stall_E(v0[6]),
    .flush_F(v0[5]), .flush_D(v0[4]), .flush_E(v0[3]),
    .alu_en(v0[2]), .busy(v0[1]), .mem_err(v0[0]), .stall_cnt(sc0)
  );

  pipe_hazard_sequencer #(
    .BR_FLUSH_CYCLES(3), .LU_STALL_CYCLES(3), .MEM_TIMEOUT(5), .PERF_W(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .branch_en(branch_en), .load_use_hzd(load_use_hzd),
    .mem_req_E(mem_req_E), .mem_ack(mem_ack),
    .stall_F(v1[8]), .stall_D(v1[7]), .stall_E(v1[6]),
    .flush_F(v1[5]), .flush_D(v1[4]), .flush_E(v1[3]),
    .alu_en(v1[2]), .busy(v1[1]), .mem_err(v1[0]), .stall_cnt(sc1)
  );

  // Output patterns (busy / mem_err added separately)
  localparam logic [8:0] P_IDLE = 9'b000_000_100;
  localparam logic [8:0] P_BR   = 9'b000_110_000;
  localparam logic [8:0] P_LU   = 9'b110_001_100;
  localparam logic [8:0] P_MEM  = 9'b111_000_000;

  int br_len[2]  = '{2, 3};
  int lu_len[2]  = '{1, 3};
  int tmo_len[2] = '{15, 5};
  int sat_max[2] = '{65535, 15};

  // Model: a committed pattern with cycles still to run, or an open memory wait
  int plan_kind[2];   // 1 = branch flush, 2 = load-use bubble
  int plan_left[2];
  bit mem_wait[2];
  int waited[2];
  int scnt[2];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [8:0] expect_vec(input int i);
    logic [8:0] r;
    if (!rst_n) return P_IDLE;
    if (plan_left[i] > 0) return ((plan_kind[i] == 1) ? P_BR : P_LU) | 9'b10;
    if (mem_wait[i]) begin
      r = P_MEM | 9'b10;
      if (waited[i] == tmo_len[i] - 1 && !mem_ack) r[0] = 1'b1;
      return r;
    end
    if (branch_en) return P_BR;
    if (mem_req_E && !mem_ack) return P_MEM;
    if (load_use_hzd) return P_LU;
    return P_IDLE;
  endfunction

  task automatic model_step(input int i);
    logic [8:0] e;
    if (!rst_n) begin
      plan_left[i] = 0; plan_kind[i] = 0; mem_wait[i] = 0; waited[i] = 0; scnt[i] = 0;
      return;
    end
    e = expect_vec(i);
    if ((|e[8:6]) && scnt[i] < sat_max[i]) scnt[i]++;
    if (plan_left[i] > 0) begin
      if (plan_kind[i] == 2 && branch_en) plan_left[i] = 0;
      else plan_left[i]--;
    end else if (mem_wait[i]) begin
      waited[i]++;
      if (mem_ack || waited[i] == tmo_len[i]) mem_wait[i] = 0;
    end else if (branch_en) begin
      plan_kind[i] = 1; plan_left[i] = br_len[i] - 1;
    end else if (mem_req_E && !mem_ack) begin
      mem_wait[i] = 1; waited[i] = 0;
    end else if (load_use_hzd) begin
      plan_kind[i] = 2; plan_left[i] = lu_len[i] - 1;
    end
  endtask

  // Compare on the falling edge, advance the model on the rising edge
  initial begin
    for (int i = 0; i < 2; i++) begin
      plan_left[i] = 0; plan_kind[i] = 0; mem_wait[i] = 0; waited[i] = 0; scnt[i] = 0;
    end
    forever begin
      @(negedge clk);
      chk("vec0", 32'(v0), 32'(expect_vec(0)));
      chk("vec1", 32'(v1), 32'(expect_vec(1)));
      chk("scnt0", 32'(sc0), rst_n ? scnt[0] : 0);
      chk("scnt1", 32'(sc1), rst_n ? scnt[1] : 0);
      @(posedge clk);
      model_step(0);
      model_step(1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    branch_en = 0; load_use_hzd = 0; mem_req_E = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    step();
    step();
    rst_n = 1;
  endtask

  initial begin
    do_reset();

    // Branch flush lasts two cycles
    branch_en = 1;
    #1;
    chk("br_c1_flushF", v0[5], 1); chk("br_c1_flushD", v0[4], 1);
    chk("br_c1_alu", v0[2], 0);    chk("br_c1_busy", v0[1], 0);
    step(); branch_en = 0; #1;
    chk("br_c2_flushF", v0[5], 1); chk("br_c2_flushD", v0[4], 1);
    chk("br_c2_alu", v0[2], 0);    chk("br_c2_busy", v0[1], 1);
    step(); #1;
    chk("br_c3_flushF", v0[5], 0); chk("br_c3_busy", v0[1], 0); chk("br_c3_alu", v0[2], 1);

    // Single load-use bubble
    do_reset();
    load_use_hzd = 1;
    #1;
    chk("lu_stallF", v0[8], 1); chk("lu_stallD", v0[7], 1);
    chk("lu_flushE", v0[3], 1); chk("lu_busy", v0[1], 0);
    step(); load_use_hzd = 0; #1;
    chk("lu_after_stallF", v0[8], 0); chk("lu_after_busy", v0[1], 0);
    chk("lu_scnt", 32'(sc0), 1);

    // Memory wait with ack on the fourth cycle
    do_reset();
    mem_req_E = 1;
    for (int k = 0; k < 3; k++) begin
      #1; chk("mw_stallE", v0[6], 1);
      step();
    end
    mem_ack = 1;
    #1; chk("mw_ack_stallE", v0[6], 1); chk("mw_ack_busy", v0[1], 1);
    step(); idle_inputs(); #1;
    chk("mw_done_stallE", v0[6], 0); chk("mw_done_busy", v0[1], 0);
    chk("mw_scnt", 32'(sc0), 4);
    chk("model_scnt", scnt[0], 4);

    // Memory timeout: mem_err on cycle 16
    do_reset();
    mem_req_E = 1;
    for (int c = 1; c <= 16; c++) begin
      #1; chk("tmo_err", v0[0], (c == 16) ? 1 : 0);
      step();
    end
    mem_req_E = 0;
    #1; chk("tmo_busy", v0[1], 0); chk("tmo_err_after", v0[0], 0);

    // Branch wins over load-use; acked request needs no stall
    do_reset();
    branch_en = 1; load_use_hzd = 1;
    #1;
    chk("pri_flushF", v0[5], 1); chk("pri_stallF", v0[8], 0); chk("pri_flushE", v0[3], 0);
    step(); idle_inputs();
    step();
    mem_req_E = 1; mem_ack = 1;
    #1;
    chk("ackrun_stallF", v0[8], 0); chk("ackrun_busy", v0[1], 0); chk("ackrun_alu", v0[2], 1);
    step(); idle_inputs();

    // Reset asserted mid memory wait
    do_reset();
    mem_req_E = 1;
    step(); step(); step();
    #1; chk("rst_pre_busy", v0[1], 1);
    rst_n = 0;
    #1;
    chk("rst_busy", v0[1], 0); chk("rst_stallF", v0[8], 0); chk("rst_stallE", v0[6], 0);
    chk("rst_alu", v0[2], 1);  chk("rst_scnt", 32'(sc0), 0);
    step(); step();
    rst_n = 1; mem_req_E = 0;
    step();

    // Randomised traffic, occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      branch_en    = ($urandom_range(0, 9) == 0);
      load_use_hzd = ($urandom_range(0, 6) == 0);
      mem_req_E    = ($urandom_range(0, 2) == 0);
      mem_ack      = ($urandom_range(0, 4) < 2);
      step();
    end
    rst_n = 1;
    idle_inputs();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
